piano_tone_gen: RTL and testbench

Square-wave note player directly downstream of the piano scale ROM. It accepts one note at a time over a valid/ready handshake: a 24-bit half-period in clock cycles (the ROM's `data` output) and a duration in milliseconds. It drives a square wave on `audio_out` for that duration, then inserts a fixed silent gap and pulses `note_done`. A 24-bit value of 0 (unmapped key) plays as a rest.

---
 rtl/piano_tone_gen.sv | 144 ++++++++++++++
 tb/tb_piano_tone_gen.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/piano_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : piano_tone_gen
// Description : Square-wave note player with valid/ready note intake, rests,
//               a fixed post-note silent gap, stop and a completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module piano_tone_gen #(
    parameter int MS_TICKS = 100000,
    parameter int GAP_MS   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [23:0] half_period,
    input  logic [11:0] dur_ms,
    input  logic        stop,
    output logic        audio_out,
    output logic        amp_en,
    output logic        busy,
    output logic        note_done
);

    localparam int              C_PW        = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(MS_TICKS - 1);
    localparam logic [11:0]     C_GAP_MS    = 12'(GAP_MS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state;
    logic [23:0]     r_hp;
    logic [23:0]     r_half_cnt;
    logic [C_PW-1:0] r_presc;
    logic [11:0]     r_ms_rem;
    logic            r_audio;
    logic            r_amp;
    logic            r_done;

    logic w_accept;
    logic w_ms_tick;
    logic w_last_ms;

    assign note_ready = rst_n & (r_state == S_IDLE) & ~stop;
    assign busy       = (r_state != S_IDLE);
    assign audio_out  = r_audio;
    assign amp_en     = r_amp;
    assign note_done  = r_done;

    assign w_accept  = note_valid & note_ready;
    assign w_ms_tick = (r_presc == C_PRESC_MAX);
    // The millisecond counter is shared by PLAY (note length) and GAP (gap length).
    assign w_last_ms = w_ms_tick & (r_ms_rem == 12'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hp       <= 24'd0;
            r_half_cnt <= 24'd0;
            r_presc    <= '0;
            r_ms_rem   <= 12'd0;
            r_audio    <= 1'b0;
            r_amp      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hp       <= half_period;
                        r_half_cnt <= 24'd0;
                        r_presc    <= '0;
                        r_ms_rem   <= dur_ms;
                        if (dur_ms == 12'd0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_PLAY;
                        end
                    end
                end

                S_PLAY: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        r_audio <= 1'b0;
                        r_amp   <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_presc <= w_ms_tick ? '0 : r_presc + 1'b1;
                        if (w_last_ms) begin
                            r_audio <= 1'b0;
                            r_amp   <= 1'b0;
                            if (C_GAP_MS == 12'd0) begin
                                r_state <= S_IDLE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state  <= S_GAP;
                                r_ms_rem <= C_GAP_MS;
                            end
                        end else begin
                            if (w_ms_tick) begin
                                r_ms_rem <= r_ms_rem - 12'd1;
                            end
                            r_amp <= (r_hp != 24'd0);
                            // A zero half-period is a rest: the wave never toggles.
                            if (r_hp != 24'd0) begin
                                if (r_half_cnt == r_hp - 24'd1) begin
                                    r_half_cnt <= 24'd0;
                                    r_audio    <= ~r_audio;
                                end else begin
                                    r_half_cnt <= r_half_cnt + 24'd1;
                                end
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (stop || w_last_ms) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_presc <= w_ms_tick ? '0 : r_presc + 1'b1;
                        if (w_ms_tick) begin
                            r_ms_rem <= r_ms_rem - 12'd1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_audio <= 1'b0;
                    r_amp   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piano_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_piano_tone_gen
// Description : Self-checking bench for piano_tone_gen (MS_TICKS=10, GAP_MS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_tone_gen;

    localparam int MS  = 10;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        note_valid = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] half_period = 24'd0;
    logic [11:0] dur_ms = 12'd0;
    logic        note_ready, audio_out, amp_en, busy, note_done;

    piano_tone_gen #(.MS_TICKS(MS), .GAP_MS(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .half_period(half_period),
        .dur_ms     (dur_ms),
        .stop       (stop),
        .audio_out  (audio_out),
        .amp_en     (amp_en),
        .busy       (busy),
        .note_done  (note_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit audio;
        bit amp;
        bit busy;
        bit done;
    } exp_t;

    typedef struct {
        int hp;
        int dur;
        int stop_k;
        int rst_k;
        int exp_changes;
        int exp_done_k;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs k edges after the accept edge, straight from the note timeline.
    function automatic exp_t model(int k, int hp, int dur, int stop_k, int rst_k);
        exp_t e;
        int   end_play, cut;
        e = '{0, 0, 0, 0};
        if (rst_k > 0 && k >= rst_k) return e;
        if (dur == 0) begin
            e.done = (k == 0);
            return e;
        end
        end_play = dur * MS;
        cut      = (stop_k > 0) ? stop_k : (dur + GAP) * MS;
        if (k >= cut) begin
            e.done = (k == cut);
            return e;
        end
        e.busy  = 1'b1;
        e.amp   = (hp != 0) && (k >= 1) && (k < end_play);
        e.audio = (hp != 0) && (k < end_play) && (((k / hp) % 2) == 1);
        return e;
    endfunction

    task automatic run_note(input int hp, input int dur, input int stop_k, input int rst_k,
                            input int obs, input bit keep_valid,
                            output int changes, output int done_k);
        exp_t e;
        logic prev_audio;
        half_period = 24'(hp);
        dur_ms      = 12'(dur);
        note_valid  = 1'b1;
        chk($sformatf("accept_ready hp=%0d dur=%0d", hp, dur), note_ready, 1);
        changes    = 0;
        done_k     = -1;
        prev_audio = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= obs; k++) begin
            @(negedge clk);
            if (k == 0 && !keep_valid) note_valid = 1'b0;
            e = model(k, hp, dur, stop_k, rst_k);
            chk($sformatf("audio_out hp=%0d k=%0d", hp, k), audio_out, e.audio);
            chk($sformatf("amp_en hp=%0d k=%0d", hp, k), amp_en, e.amp);
            chk($sformatf("busy hp=%0d k=%0d", hp, k), busy, e.busy);
            chk($sformatf("note_done hp=%0d k=%0d", hp, k), note_done, e.done);
            chk($sformatf("note_ready hp=%0d k=%0d", hp, k), note_ready,
                !e.busy && !stop && rst_n);
            if (audio_out !== prev_audio) changes++;
            prev_audio = audio_out;
            if (note_done === 1'b1 && done_k < 0) done_k = k;
            stop  = (stop_k > 0) && (k == stop_k - 1);
            rst_n = !((rst_k > 0) && (k == rst_k - 1));
        end
    endtask

    vec_t vecs[9];

    initial begin
        int ch, dk, hp, dur, stop_k, cut;

        vecs[0] = '{3,  2, 0,  0,  6, 40};   // tone
        vecs[1] = '{0,  1, 0,  0,  0, 30};   // rest
        vecs[2] = '{5,  0, 0,  0,  0,  0};   // zero duration
        vecs[3] = '{4,  3, 8,  0,  2,  8};   // stop during PLAY
        vecs[4] = '{1,  1, 0,  0, 10, 30};   // fastest toggle
        vecs[5] = '{7,  1, 0,  0,  2, 30};
        vecs[6] = '{25, 3, 0,  0,  2, 50};
        vecs[7] = '{2,  1, 25, 0,  4, 25};   // stop during GAP
        vecs[8] = '{3,  2, 0, 12,  4, -1};   // reset mid-note, no done

        // Reset state; note_ready must be held low while rst_n is low
        repeat (2) @(negedge clk);
        chk("reset audio_out", audio_out, 0);
        chk("reset amp_en", amp_en, 0);
        chk("reset busy", busy, 0);
        chk("reset note_done", note_done, 0);
        chk("reset note_ready", note_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset note_ready", note_ready, 1);

        foreach (vecs[i]) begin
            cut = (vecs[i].rst_k > 0) ? vecs[i].rst_k + 2 : vecs[i].exp_done_k + 2;
            run_note(vecs[i].hp, vecs[i].dur, vecs[i].stop_k, vecs[i].rst_k, cut, 1'b0, ch, dk);
            chk($sformatf("vec%0d audio changes", i), ch, vecs[i].exp_changes);
            chk($sformatf("vec%0d done edge", i), dk, vecs[i].exp_done_k);
        end

        // Back-to-back: second note taken on the first note's done cycle
        run_note(2, 1, 0, 0, 30, 1'b1, ch, dk);
        chk("b2b first done edge", dk, 30);
        run_note(6, 1, 0, 0, 32, 1'b0, ch, dk);
        chk("b2b second changes", ch, 2);
        chk("b2b second done edge", dk, 30);

        // stop held in IDLE blocks acceptance
        stop        = 1'b1;
        note_valid  = 1'b1;
        half_period = 24'd5;
        dur_ms      = 12'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stop-idle note_ready c=%0d", c), note_ready, 0);
            chk($sformatf("stop-idle busy c=%0d", c), busy, 0);
        end
        note_valid = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        chk("stop-idle release busy", busy, 0);
        chk("stop-idle release ready", note_ready, 1);

        // Randomized notes against the timeline model
        for (int r = 0; r < 20; r++) begin
            hp     = $urandom_range(0, 12);
            dur    = $urandom_range(0, 3);
            stop_k = 0;
            if (dur > 0 && $urandom_range(0, 3) == 0)
                stop_k = $urandom_range(1, (dur + GAP) * MS - 1);
            cut = (dur == 0) ? 0 : ((stop_k > 0) ? stop_k : (dur + GAP) * MS);
            run_note(hp, dur, stop_k, 0, cut + 2, 1'b0, ch, dk);
            chk($sformatf("rand%0d done edge", r), dk, cut);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
